// File: rtl/sysid_verify_ctrl.sv
// Reads the sysid ID (address 0) and timestamp (address 1) words over Avalon-MM,
// compares them with build-time constants and reports pass, mismatch or timeout.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h52EE_3423,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    R_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_gap;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_retry;
  logic          r_pass;
  logic          r_id_mis;
  logic          r_ts_mis;
  logic          r_timeout;
  logic [31:0]   r_id_value;
  logic [31:0]   r_ts_value;

  logic w_start;
  logic w_active;
  logic w_accept;
  logic w_stall;
  logic w_expire;
  logic w_give_up;

  assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // r_gap marks the single idle cycle between an abandoned read and its reissue
  assign w_active  = ((r_state == S_RD_ID) || (r_state == S_RD_TS)) && !r_gap;
  assign w_accept  = w_active && !avm_waitrequest;
  assign w_stall   = w_active && avm_waitrequest;
  assign w_expire  = w_stall && (r_tcnt == T_LIMIT - TW'(1));
  assign w_give_up = w_expire && (r_retry >= R_LIMIT);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD_ID;
      end
      S_RD_ID: begin
        avm_read = !r_gap;
        busy     = 1'b1;
        if (w_give_up)     w_next = S_DONE;
        else if (w_accept) w_next = S_RD_TS;
      end
      S_RD_TS: begin
        avm_read    = !r_gap;
        avm_address = 1'b1;
        busy        = 1'b1;
        if (w_give_up)     w_next = S_DONE;
        else if (w_accept) w_next = S_CHECK;
      end
      S_CHECK: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_RD_ID;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_gap      <= 1'b0;
      r_tcnt     <= '0;
      r_retry    <= '0;
      r_pass     <= 1'b0;
      r_id_mis   <= 1'b0;
      r_ts_mis   <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      if (w_start) begin
        r_gap     <= 1'b0;
        r_tcnt    <= '0;
        r_retry   <= '0;
        r_pass    <= 1'b0;
        r_id_mis  <= 1'b0;
        r_ts_mis  <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_accept) begin
        if (r_state == S_RD_ID) r_id_value <= avm_readdata;
        else                    r_ts_value <= avm_readdata;
        r_tcnt  <= '0;
        r_retry <= '0;
      end else if (w_stall) begin
        if (w_expire) begin
          r_tcnt <= '0;
          if (w_give_up) r_timeout <= 1'b1;
          else           r_gap     <= 1'b1;
        end else if (r_tcnt != T_LIMIT) begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
      if (r_gap) begin
        r_gap <= 1'b0;
        if (r_retry != 4'hF) r_retry <= r_retry + 4'd1;
      end
      if (r_state == S_CHECK) begin
        r_id_mis <= (r_id_value != EXPECTED_ID);
        r_ts_mis <= (r_ts_value != EXPECTED_TS);
        r_pass   <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
      end
    end
  end

  assign pass        = r_pass;
  assign id_mismatch = r_id_mis;
  assign ts_mismatch = r_ts_mis;
  assign timeout_err = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Self-checking bench for sysid_verify_ctrl: a default-parameter instance and a
// short-timeout instance (TIMEOUT_CYCLES=4, MAX_RETRIES=2) driven by a model slave.
module tb_sysid_verify_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h52EE_3423;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [2];
  logic        start_s [2];
  logic        wr_s    [2];
  logic [31:0] rdata_s [2];
  logic        rd_s    [2];
  logic        adr_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic        idm_s   [2];
  logic        tsm_s   [2];
  logic        to_s    [2];
  logic [31:0] idv_s   [2];
  logic [31:0] tsv_s   [2];

  logic [31:0] mid [2];
  logic [31:0] mts [2];

  int checks = 0;
  int errors = 0;

  sysid_verify_ctrl u_dut0 (
    .clock(clk), .reset_n(rst_n[0]), .start(start_s[0]),
    .avm_address(adr_s[0]), .avm_read(rd_s[0]), .avm_readdata(rdata_s[0]),
    .avm_waitrequest(wr_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .id_mismatch(idm_s[0]), .ts_mismatch(tsm_s[0]), .timeout_err(to_s[0]),
    .id_value(idv_s[0]), .ts_value(tsv_s[0])
  );

  sysid_verify_ctrl #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) u_dut1 (
    .clock(clk), .reset_n(rst_n[1]), .start(start_s[1]),
    .avm_address(adr_s[1]), .avm_read(rd_s[1]), .avm_readdata(rdata_s[1]),
    .avm_waitrequest(wr_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .id_mismatch(idm_s[1]), .ts_mismatch(tsm_s[1]), .timeout_err(to_s[1]),
    .id_value(idv_s[1]), .ts_value(tsv_s[1])
  );

  typedef struct {
    bit rd;
    bit adr;
    bit bsy;
  } cyc_t;

  typedef struct {
    int          d;
    logic [31:0] idw;
    logic [31:0] tsw;
    int          w0;
    int          w1;
    bit          e_pass;
    bit          e_idm;
    bit          e_tsm;
    bit          e_to;
    int          e_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Slave stalls the first w0/w1 read cycles seen on each address (counted across
  // retries); the expected bus trace is derived from those stall budgets.
  task automatic run_seq(input int d, input logic [31:0] idw, input logic [31:0] tsw,
                         input int w0, input int w1, input string nm, output int lat);
    cyc_t q[$];
    int   wt [2];
    int   used [2];
    int   tmo, mr, left, tries, s, a;
    bit   got, to_any, to_id;
    tmo = (d == 0) ? 255 : 4;
    mr  = (d == 0) ? 3 : 2;
    wt[0] = w0; wt[1] = w1;
    used[0] = 0; used[1] = 0;
    to_any = 1'b0; to_id = 1'b0;
    for (int w = 0; w < 2 && !to_any; w++) begin
      left = wt[w]; tries = 0; got = 1'b0;
      while (!got && !to_any) begin
        s = 0;
        while (!got && s < tmo) begin
          q.push_back('{1'b1, w[0], 1'b1});
          if (left == 0) got = 1'b1;
          else begin left--; s++; end
        end
        if (!got) begin
          if (tries == mr) begin
            to_any = 1'b1;
            if (w == 0) to_id = 1'b1;
          end else begin
            q.push_back('{1'b0, w[0], 1'b1});
            tries++;
          end
        end
      end
    end
    if (!to_any) q.push_back('{1'b0, 1'b0, 1'b1});

    @(negedge clk);
    start_s[d] = 1'b1;
    wr_s[d]    = 1'b0;
    @(negedge clk);
    start_s[d] = 1'b0;
    lat = 0;
    foreach (q[i]) begin
      lat++;
      chk({nm, "_cyc"}, 64'({rd_s[d], adr_s[d], busy_s[d], done_s[d]}),
          64'({q[i].rd, q[i].adr, q[i].bsy, 1'b0}));
      a = adr_s[d] ? 1 : 0;
      wr_s[d]    = (used[a] < wt[a]);
      rdata_s[d] = (a == 1) ? tsw : idw;
      if (rd_s[d] && wr_s[d]) used[a]++;
      @(negedge clk);
    end
    lat++;
    wr_s[d] = 1'b0;
    if (!to_id) mid[d] = idw;
    if (!to_any) mts[d] = tsw;
    chk({nm, "_done"}, 64'({rd_s[d], busy_s[d], done_s[d]}), 64'({1'b0, 1'b0, 1'b1}));
    chk({nm, "_to"}, 64'(to_s[d]), 64'(to_any));
    chk({nm, "_idm"}, 64'(idm_s[d]), 64'(!to_any && (idw != EXP_ID)));
    chk({nm, "_tsm"}, 64'(tsm_s[d]), 64'(!to_any && (tsw != EXP_TS)));
    chk({nm, "_pass"}, 64'(pass_s[d]), 64'(!to_any && (idw == EXP_ID) && (tsw == EXP_TS)));
    chk({nm, "_idv"}, 64'(idv_s[d]), 64'(mid[d]));
    chk({nm, "_tsv"}, 64'(tsv_s[d]), 64'(mts[d]));
  endtask

  vec_t tbl [12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          d;
    logic [31:0] idw, tsw;
    int          w0, w1;

    tbl[0]  = '{0, EXP_ID,        EXP_TS,        0,    0,    1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[1]  = '{0, 32'h0000_0001, EXP_TS,        0,    0,    1'b0, 1'b1, 1'b0, 1'b0, 4};
    tbl[2]  = '{0, EXP_ID,        32'h52EE_3424, 0,    0,    1'b0, 1'b0, 1'b1, 1'b0, 4};
    tbl[3]  = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 0,    0,    1'b0, 1'b1, 1'b1, 1'b0, 4};
    tbl[4]  = '{0, EXP_ID,        EXP_TS,        0,    10,   1'b1, 1'b0, 1'b0, 1'b0, 14};
    tbl[5]  = '{1, EXP_ID,        EXP_TS,        1000, 0,    1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[6]  = '{1, EXP_ID,        EXP_TS,        0,    5,    1'b1, 1'b0, 1'b0, 1'b0, 10};
    tbl[7]  = '{1, EXP_ID,        EXP_TS,        8,    0,    1'b1, 1'b0, 1'b0, 1'b0, 14};
    tbl[8]  = '{1, EXP_ID,        EXP_TS,        12,   0,    1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[9]  = '{1, EXP_ID,        EXP_TS,        0,    1000, 1'b0, 1'b0, 1'b0, 1'b1, 16};
    tbl[10] = '{0, EXP_ID,        EXP_TS,        765,  0,    1'b1, 1'b0, 1'b0, 1'b0, 772};
    tbl[11] = '{0, 32'h0000_0005, EXP_TS,        2000, 0,    1'b0, 1'b0, 1'b0, 1'b1, 1024};

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; start_s[k] = 1'b0; wr_s[k] = 1'b0; rdata_s[k] = '0;
      mid[k] = '0; mts[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ctl%0d", k),
          64'({rd_s[k], adr_s[k], busy_s[k], done_s[k], pass_s[k], idm_s[k], tsm_s[k], to_s[k]}), 64'(0));
      chk($sformatf("reset_val%0d", k), 64'({idv_s[k], tsv_s[k]}), 64'(0));
      rst_n[k] = 1'b1;
    end

    for (int i = 0; i < 12; i++) begin
      run_seq(tbl[i].d, tbl[i].idw, tbl[i].tsw, tbl[i].w0, tbl[i].w1, $sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].e_lat));
      chk($sformatf("vec%0d_flags", i),
          64'({pass_s[tbl[i].d], idm_s[tbl[i].d], tsm_s[tbl[i].d], to_s[tbl[i].d]}),
          64'({tbl[i].e_pass, tbl[i].e_idm, tbl[i].e_tsm, tbl[i].e_to}));
    end

    // Reset asserted while the timestamp read is on the bus.
    @(negedge clk);
    start_s[0] = 1'b1; wr_s[0] = 1'b0; rdata_s[0] = 32'h1234_5678;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("rst_mid_rdid", 64'({rd_s[0], adr_s[0]}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    chk("rst_mid_rdts", 64'({rd_s[0], adr_s[0], busy_s[0]}), 64'({1'b1, 1'b1, 1'b1}));
    rst_n[0] = 1'b0; wr_s[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", 64'({rd_s[0], busy_s[0], done_s[0], pass_s[0]}), 64'(0));
    chk("rst_mid_idv", 64'(idv_s[0]), 64'(0));
    rst_n[0] = 1'b1; wr_s[0] = 1'b0;
    mid[0] = '0; mts[0] = '0;
    @(negedge clk);
    chk("rst_mid_idle", 64'({rd_s[0], busy_s[0], done_s[0]}), 64'(0));
    run_seq(0, EXP_ID, EXP_TS, 0, 0, "post_rst", lat);
    chk("post_rst_lat", 64'(lat), 64'(4));

    // start held high: no restart while busy, immediate restart from DONE.
    @(negedge clk);
    start_s[0] = 1'b1; wr_s[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      case ((k - 1) % 4)
        0:       chk($sformatf("hold_c%0d", k), 64'({rd_s[0], adr_s[0], busy_s[0], done_s[0]}), 64'(4'b1010));
        1:       chk($sformatf("hold_c%0d", k), 64'({rd_s[0], adr_s[0], busy_s[0], done_s[0]}), 64'(4'b1110));
        2:       chk($sformatf("hold_c%0d", k), 64'({rd_s[0], adr_s[0], busy_s[0], done_s[0]}), 64'(4'b0010));
        default: begin
          chk($sformatf("hold_c%0d", k), 64'({rd_s[0], adr_s[0], busy_s[0], done_s[0]}), 64'(4'b0001));
          chk($sformatf("hold_pass%0d", k), 64'(pass_s[0]), 64'(1));
        end
      endcase
      rdata_s[0] = adr_s[0] ? EXP_TS : EXP_ID;
      if (k == 8) start_s[0] = 1'b0;
    end
    mid[0] = EXP_ID; mts[0] = EXP_TS;
    @(negedge clk);
    chk("hold_stay_done", 64'({busy_s[0], done_s[0], pass_s[0]}), 64'(3'b011));

    for (int r = 0; r < 40; r++) begin
      d   = int'($urandom_range(0, 1));
      idw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      tsw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      w0  = (d == 1) ? int'($urandom_range(0, 13)) : int'($urandom_range(0, 6));
      w1  = (d == 1) ? int'($urandom_range(0, 13)) : int'($urandom_range(0, 6));
      run_seq(d, idw, tsw, w0, w1, $sformatf("rnd%0d", r), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_verify_ctrl.md
SYSID_VERIFY_CTRL -- requirements
Module: sysid_verify_ctrl

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000: expected system ID word at sysid address 0.
REQ-002 Parameter EXPECTED_TS, default 32'h52EE_3423: expected timestamp word at sysid address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a read may stall before it is abandoned; legal range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: retries allowed per word after a timeout; legal range 0..15.
REQ-005 clock  in  1  single system clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  pulse or level; begins a check sequence when sampled high in IDLE or DONE.
REQ-008 avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_readdata  in  32  sysid read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 avm_waitrequest  in  1  slave stall; tie low for a zero-wait-state sysid slave.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  high while in DONE; cleared by a new start or by reset.
REQ-014 pass  out  1  valid while done=1: both words match and no timeout occurred.
REQ-015 id_mismatch / ts_mismatch / timeout_err  out  1 each  sticky error flags, valid while done=1.
REQ-016 id_value / ts_value  out  32 each  last word captured from each address.

Function
REQ-017 FSM states: IDLE, RD_ID, RD_TS, CHECK, DONE.
REQ-018 IDLE or DONE with start=1 -> RD_ID on the next edge; clear pass, all error flags, the retry counter and the timeout counter; keep id_value and ts_value.
REQ-019 RD_ID: drive avm_read=1 and avm_address=0. Hold both stable while avm_waitrequest=1.
REQ-020 RD_ID, in the first cycle with avm_waitrequest=0: capture avm_readdata into id_value, reset the timeout and retry counters, go to RD_TS. The handshake takes 1 cycle with zero wait states.
REQ-021 RD_TS: same behaviour with avm_address=1; capture into ts_value; go to CHECK.
REQ-022 Timeout counter increments each RD_x cycle with avm_waitrequest=1. When it reaches TIMEOUT_CYCLES, deassert avm_read for exactly 1 cycle (same state, counter cleared), then reissue the read and increment the retry counter.
REQ-023 If a timeout occurs with retry count already = MAX_RETRIES: set timeout_err, go to DONE, skip the remaining reads and CHECK, and leave pass=0.
REQ-024 CHECK (1 cycle):
- id_mismatch = (id_value != EXPECTED_ID)
- ts_mismatch = (ts_value != EXPECTED_TS)
- pass = !(either mismatch)
- then go to DONE.
REQ-025 DONE: done=1, busy=0, avm_read=0; outputs hold until start or reset.
REQ-026 avm_read is 0 in IDLE, CHECK and DONE. It is never asserted for 2 back-to-back accepted transfers without a state change.
REQ-027 start is ignored while busy=1.
REQ-028 Total latency from start to done is 4 cycles with zero wait states: start edge, RD_ID, RD_TS, CHECK, DONE.
REQ-029 Counters saturate rather than wrap; the timeout counter width is ceil(log2(TIMEOUT_CYCLES+1)).

Reset
REQ-030 reset_n=0 sampled on an edge forces IDLE. avm_read=0, avm_address=0, busy=0, done=0, pass=0, all error flags=0, id_value=0, ts_value=0, counters=0.
REQ-031 A reset in the middle of a sequence aborts the sequence in that cycle with no further bus activity. start must be reasserted after reset_n=1.
REQ-032 There is no asynchronous path from reset_n to any output.

Verification
REQ-033 Zero-wait slave returning 0 at addr 0 and 0x52EE3423 at addr 1, start pulse -> done=1 and pass=1 exactly 4 cycles later; addresses issued in order 0, 1.
REQ-034 Slave returns 0x00000001 at addr 0 -> done=1, pass=0, id_mismatch=1, ts_mismatch=0, id_value=1.
REQ-035 waitrequest held for 10 cycles on addr 1 with TIMEOUT_CYCLES=255 -> avm_read and avm_address stable throughout, no retry, pass=1, done at cycle 14.
REQ-036 waitrequest stuck high with TIMEOUT_CYCLES=4 and MAX_RETRIES=2 -> 3 read attempts, each separated by a 1-cycle avm_read gap; then timeout_err=1, pass=0, done=1, ts_value unchanged.
REQ-037 reset_n=0 asserted during RD_TS -> next cycle avm_read=0, busy=0, id_value=0; a later start runs a full clean sequence.
REQ-038 start held high through a sequence -> no restart while busy. After DONE is entered, the sequence restarts on the next edge and done clears.
